// File: rtl/cardinal_mon_pkg.sv
// Shared types and helpers for the Cardinal run monitor.
//   mon_state_e       : run/dump controller states
//   HALT_INST_DEFAULT : instruction value that marks program end
//   clog2_min1()      : index width helper, never returns 0
package cardinal_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_RD,
        ST_CAP,
        ST_OUT,
        ST_DONE
    } mon_state_e;

    localparam logic [31:0] HALT_INST_DEFAULT = 32'h0;

    // A single node still needs a 1-bit index port.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cardinal_run_monitor_run_counter.sv
// Per-node run-length counter.
//   clear   : zero count and done flag (new run armed)
//   enable  : controller is in RUN
//   halt    : node fetched the halt instruction this cycle
//   freeze  : run ended by timeout, stop counting
//   count   : cycles run so far, saturating at all-ones
//   done    : node has halted; count frozen from then on
module cardinal_run_monitor_run_counter #(
    parameter int CNT_W = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             halt,
    input  logic             freeze,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (enable && !done_q && !freeze) begin
            // The halt cycle itself is counted.
            if (count_q != '1)
                count_d = count_q + 1'b1;
            if (halt)
                done_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule

// File: rtl/cardinal_run_monitor.sv
// Run controller for a multi-node Cardinal array: counts cycles per node
// until each fetches the halt instruction, waits a flush interval, then
// walks every node's dmem through a read side-port and streams the words.
//   start                  : arm a run (IDLE/DONE only)
//   node_inst              : per-node instruction bus, node 0 in LSBs
//   dump_mem_en/node/addr  : dmem side-port read request
//   dump_rd_data           : per-node dmem read data, one cycle after request
//   out_valid/ready/node/addr/data : dump word stream
//   cycle_count, node_done : per-node run length and halt flags
//   busy, timeout          : controller active; run ended by MAX_CYCLES
module cardinal_run_monitor
    import cardinal_mon_pkg::*;
#(
    parameter int                NODES        = 4,
    parameter int                INST_W       = 32,
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 64,
    parameter int                DUMP_DEPTH   = 128,
    parameter int                FLUSH_CYCLES = 5,
    parameter int                CNT_W        = 32,
    parameter int                MAX_CYCLES   = 0,
    parameter logic [INST_W-1:0] HALT_INST    = INST_W'(HALT_INST_DEFAULT),
    localparam int               NODE_W       = clog2_min1(NODES)
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           start,
    input  logic [NODES-1:0][INST_W-1:0]   node_inst,
    output logic                           dump_mem_en,
    output logic [NODE_W-1:0]              dump_node,
    output logic [ADDR_W-1:0]              dump_addr,
    input  logic [NODES-1:0][DATA_W-1:0]   dump_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NODE_W-1:0]              out_node,
    output logic [ADDR_W-1:0]              out_addr,
    output logic [DATA_W-1:0]              out_data,
    output logic [NODES-1:0][CNT_W-1:0]    cycle_count,
    output logic [NODES-1:0]               node_done,
    output logic                           busy,
    output logic                           timeout
);

    localparam int FL_W = clog2_min1(FLUSH_CYCLES);

    mon_state_e        state_q, state_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              timeout_q, timeout_d;

    logic [NODES-1:0]  halt_vec;
    logic              run_clear;
    logic              run_en;
    logic              all_done_next;

    always_comb begin
        for (int n = 0; n < NODES; n++)
            halt_vec[n] = (node_inst[n] == HALT_INST);
    end

    assign run_clear     = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign run_en        = (state_q == ST_RUN);
    // Done after this cycle's updates; lets all-done beat a same-cycle timeout.
    assign all_done_next = &(node_done | halt_vec);

    for (genvar n = 0; n < NODES; n++) begin : g_node
        cardinal_run_monitor_run_counter #(
            .CNT_W (CNT_W)
        ) u_run_counter (
            .Clock  (Clock),
            .Reset  (Reset),
            .clear  (run_clear),
            .enable (run_en),
            .halt   (halt_vec[n]),
            .freeze (timeout_q),
            .count  (cycle_count[n]),
            .done   (node_done[n])
        );
    end

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        run_cnt_d = run_cnt_q;
        node_d    = node_q;
        addr_d    = addr_q;
        data_d    = data_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                    timeout_d = 1'b0;
                    node_d    = '0;
                    addr_d    = '0;
                end
            end
            ST_RUN: begin
                if (run_cnt_q != '1)
                    run_cnt_d = run_cnt_q + 1'b1;
                if (all_done_next) begin
                    state_d = ST_FLUSH;
                    flush_d = '0;
                end else if (MAX_CYCLES != 0 && run_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    // This cycle is the MAX_CYCLES-th of the run.
                    timeout_d = 1'b1;
                    state_d   = ST_FLUSH;
                    flush_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_q == FL_W'(FLUSH_CYCLES - 1))
                    state_d = ST_RD;
                else
                    flush_d = flush_q + 1'b1;
            end
            ST_RD:  state_d = ST_CAP;
            ST_CAP: begin
                data_d  = dump_rd_data[node_q];
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_RD;
                    if (addr_q == ADDR_W'(DUMP_DEPTH - 1)) begin
                        addr_d = '0;
                        if (node_q == NODE_W'(NODES - 1)) begin
                            node_d  = '0;
                            state_d = ST_DONE;
                        end else begin
                            node_d = node_q + 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            flush_q   <= '0;
            run_cnt_q <= '0;
            node_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            run_cnt_q <= run_cnt_d;
            node_q    <= node_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
        end
    end

    // node/addr only move on an accepted word, so they serve both the read
    // request and the held output word.
    assign dump_mem_en = (state_q == ST_RD);
    assign dump_node   = node_q;
    assign dump_addr   = addr_q;
    assign out_valid   = (state_q == ST_OUT);
    assign out_node    = node_q;
    assign out_addr    = addr_q;
    assign out_data    = data_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_cardinal_run_monitor.sv
// Directed bench for cardinal_run_monitor: 2 nodes, 4-word dump, timeout 20.
module tb_cardinal_run_monitor;

    localparam logic [31:0] HALT = 32'h0;

    logic                  Clock = 1'b0;
    logic                  Reset;
    logic                  start;
    logic [1:0][31:0]      node_inst;
    logic                  dump_mem_en;
    logic                  dump_node;
    logic [7:0]            dump_addr;
    logic [1:0][63:0]      dump_rd_data = '0;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_node;
    logic [7:0]            out_addr;
    logic [63:0]           out_data;
    logic [1:0][31:0]      cycle_count;
    logic [1:0]            node_done;
    logic                  busy;
    logic                  timeout;

    int          checks = 0;
    int          errs   = 0;
    int          run_cyc = 0;
    logic        arm = 1'b0;
    int          halt_at [2] = '{0, 0};
    int          memen_cnt = 0;
    logic [95:0] wq[$];
    int          hq[$];

    cardinal_run_monitor #(
        .NODES(2), .INST_W(32), .ADDR_W(8), .DATA_W(64), .DUMP_DEPTH(4),
        .FLUSH_CYCLES(5), .CNT_W(32), .MAX_CYCLES(20), .HALT_INST(HALT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .start(start), .node_inst(node_inst),
        .dump_mem_en(dump_mem_en), .dump_node(dump_node), .dump_addr(dump_addr),
        .dump_rd_data(dump_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_node(out_node), .out_addr(out_addr), .out_data(out_data),
        .cycle_count(cycle_count), .node_done(node_done), .busy(busy), .timeout(timeout)
    );

    always #5 Clock = ~Clock;

    // run_cyc == k during the k-th cycle after the start edge.
    always @(posedge Clock) run_cyc <= arm ? 1 : run_cyc + 1;

    always_comb begin
        for (int n = 0; n < 2; n++)
            node_inst[n] = (halt_at[n] != 0 && run_cyc == halt_at[n]) ? HALT
                                                                      : (32'h100 + run_cyc);
    end

    // dmem model: node n, addr a holds a*0x11 + n*0x100.
    always @(posedge Clock)
        if (dump_mem_en)
            for (int n = 0; n < 2; n++)
                dump_rd_data[n] <= 64'h11 * dump_addr + 64'(n) * 256;

    always @(negedge Clock) begin
        if (dump_mem_en) memen_cnt++;
        if (out_valid && out_ready) begin
            wq.push_back({23'b0, out_node, out_addr, out_data});
            hq.push_back(run_cyc);
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] exp_word(input int n, input int a);
        logic [63:0] d;
        d = 64'h11 * a + 64'(n) * 256;
        return {23'b0, 1'(n), 8'(a), d};
    endfunction

    task automatic start_run(input int h0, input int h1);
        halt_at[0] = h0;
        halt_at[1] = h1;
        @(negedge Clock); start = 1'b1; arm = 1'b1;
        @(negedge Clock); start = 1'b0; arm = 1'b0;
    endtask

    task automatic wait_memen(output int cyc);
        cyc = -1;
        for (int i = 0; i < 100; i++) begin
            if (dump_mem_en) begin cyc = run_cyc; break; end
            @(negedge Clock);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) @(negedge Clock);
        check(tag, busy, 0);
    endtask

    task automatic check_dump(input string tag);
        check({tag, "_words"}, wq.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < wq.size())
                check($sformatf("%s_w%0d", tag, k), wq[k], exp_word(k / 4, k % 4));
    endtask

    initial begin
        int          cyc;
        int          bad;
        logic [95:0] held;
        int          men0;

        Reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock); Reset = 1'b0;
        @(negedge Clock);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_memen", dump_mem_en, 0);
        check("rst_counts", cycle_count, 0);
        check("rst_done", {timeout, node_done}, 0);

        // Halts at 10 and 17, flush 5, first read in cycle 23; free-running dump.
        start_run(10, 17);
        wait_memen(cyc);
        check("t1_first_memen", cyc, 23);
        check("t1_count0", cycle_count[0], 10);
        check("t1_count1", cycle_count[1], 17);
        check("t1_done", {timeout, node_done}, 3'b011);
        wait_idle("t2_idle");
        check_dump("t2");
        if (hq.size() == 8) check("t2_throughput", hq[7] - hq[0], 21);
        check("t2_hold_counts", cycle_count, {32'd17, 32'd10});

        // Consumer stall of 7 cycles on word 3.
        @(posedge Clock); #1; wq.delete(); hq.delete();
        start_run(4, 6);
        for (int i = 0; i < 200 && wq.size() < 3; i++) begin @(posedge Clock); #1; end
        for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge Clock); #1; end
        out_ready = 1'b0;
        held = {23'b0, out_node, out_addr, out_data};
        check("t3_held_word", held, exp_word(0, 3));
        men0 = memen_cnt;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge Clock); #1;
            if (!out_valid || {23'b0, out_node, out_addr, out_data} != held) bad++;
        end
        check("t3_stall_stable", bad, 0);
        check("t3_stall_no_memen", memen_cnt - men0, 0);
        out_ready = 1'b1;
        @(negedge Clock);
        wait_idle("t3_idle");
        check_dump("t3");

        // Node 1 never halts: timeout after 20 cycles, dump still runs.
        @(posedge Clock); #1; wq.delete(); hq.delete();
        start_run(7, 0);
        wait_idle("t4_idle");
        check("t4_timeout", timeout, 1);
        check("t4_count0", cycle_count[0], 7);
        check("t4_count1", cycle_count[1], 20);
        check("t4_done", node_done, 2'b01);
        check("t4_words", wq.size(), 8);

        // Reset while a word is on the output.
        start_run(3, 4);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_counts", cycle_count, 0);
        check("t5_flags", {timeout, node_done, dump_mem_en}, 0);
        @(negedge Clock); Reset = 1'b0;
        @(posedge Clock); #1; wq.delete(); hq.delete();

        // Rerun after reset; stray start in RUN; both nodes halt in cycle 9.
        start_run(9, 9);
        repeat (4) @(negedge Clock);
        start = 1'b1;
        @(negedge Clock); start = 1'b0;
        wait_memen(cyc);
        check("t6_first_memen", cyc, 15);
        check("t6_counts", cycle_count, {32'd9, 32'd9});
        check("t6_flags", {timeout, node_done}, 3'b011);
        wait_idle("t6_idle");
        check_dump("t6");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
